// File: rtl/fxp_pkg.sv
// Shared definitions for the Runge-Kutta fixed-point datapath.
package fxp_pkg;

    // Global RK Q format: Q(RK_WIDTH-RK_FRAC).RK_FRAC
    localparam int RK_WIDTH = 16;
    localparam int RK_FRAC  = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH,
        DONE
    } state_t;

    // Largest representable signed value for a w-bit word
    function automatic longint fxp_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Most negative representable signed value for a w-bit word
    function automatic longint fxp_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Rounds a full-precision signed product back to the Q format and either
// clamps or wraps it; overflow flags an out-of-range value in both modes.
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int WIDTH    = RK_WIDTH,
    parameter int FRAC     = RK_FRAC,
    parameter int ROUND_EN = 1,
    parameter int SAT_EN   = 1
) (
    input  logic signed [2*WIDTH:0] prod,
    output logic [WIDTH-1:0]        result,
    output logic                    overflow
);

    localparam int PW = 2 * WIDTH + 1;
    localparam int HS = (FRAC > 0) ? FRAC - 1 : 0;

    // Half an output LSB; zero when truncating or when there are no fraction bits
    localparam logic signed [PW-1:0] HALF =
        (ROUND_EN != 0 && FRAC > 0) ? (PW'(1) << HS) : '0;
    localparam logic signed [PW-1:0] MAXV = PW'(fxp_max(WIDTH));
    localparam logic signed [PW-1:0] MINV = PW'(fxp_min(WIDTH));

    logic signed [PW-1:0] biased;
    logic signed [PW-1:0] rnd;

    // Round half toward +inf via bias then floor shift, then range-limit
    always_comb begin
        biased   = prod + HALF;
        rnd      = biased >>> FRAC;
        overflow = (rnd > MAXV) || (rnd < MINV);
        result   = rnd[WIDTH-1:0];
        if (SAT_EN != 0) begin
            if (rnd > MAXV) begin
                result = MAXV[WIDTH-1:0];
            end else if (rnd < MINV) begin
                result = MINV[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/fxp_mult_seq.sv
// Sequential signed fixed-point multiplier: radix-2 shift-add on operand
// magnitudes (one partial product per cycle), sign fix-up, round and saturate.
// Valid/ready on both sides so several RK stage controllers can share it.
//
// state  | meaning
// IDLE   | ready for operands
// CALC   | WIDTH shift-add iterations on |a|, |b|
// FINISH | sign fix-up, round/saturate, register result
// DONE   | result presented, waiting for out_ready
module fxp_mult_seq
    import fxp_pkg::*;
#(
    parameter int WIDTH    = RK_WIDTH,
    parameter int FRAC     = RK_FRAC,
    parameter int ROUND_EN = 1,
    parameter int SAT_EN   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t              state;
    logic                in_ready_q;
    logic [WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]    mplier;
    logic [2*WIDTH-1:0]  acc;
    logic [CW-1:0]       cnt;
    logic                sign;

    logic signed [2*WIDTH:0] prod;
    logic [WIDTH-1:0]        rs_result;
    logic                    rs_overflow;

    // Magnitude of a two's complement word; the most negative value maps to
    // 2^(WIDTH-1), which still fits as unsigned
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    // Ready is held low for the whole reset cycle, not just after the edge
    assign in_ready = in_ready_q & ~rst;

    // Reapply the sign to the unsigned magnitude product
    always_comb begin
        prod = sign ? -$signed({1'b0, acc}) : $signed({1'b0, acc});
    end

    fxp_round_sat #(
        .WIDTH    (WIDTH),
        .FRAC     (FRAC),
        .ROUND_EN (ROUND_EN),
        .SAT_EN   (SAT_EN)
    ) u_round_sat (
        .prod     (prod),
        .result   (rs_result),
        .overflow (rs_overflow)
    );

    // Control FSM and shift-add datapath with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready_q <= 1'b1;
            out_valid  <= 1'b0;
            result     <= '0;
            overflow   <= 1'b0;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            sign       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        mcand      <= mag(a);
                        mplier     <= mag(b);
                        sign       <= a[WIDTH-1] ^ b[WIDTH-1];
                        acc        <= '0;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    if (mplier[0]) begin
                        acc <= acc + ({{WIDTH{1'b0}}, mcand} << cnt);
                    end
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    result    <= rs_result;
                    overflow  <= rs_overflow;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        in_ready_q <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fxp_mult_seq.md
Name: fxp_mult_seq

Overview:
- Sequential signed fixed-point multiplier for the Runge-Kutta datapath. It replaces the purely combinational, truncating A*B product.
- Computes a Q(WIDTH-FRAC).FRAC product with a radix-2 shift-add engine (one partial product per cycle), then applies selectable rounding and saturation.
- Uses valid/ready handshakes on input and output so RK stage controllers can share one multiplier and stall on it.

Parameters:
- WIDTH, 16, operand and result width in bits (min 4).
- FRAC, 8, fractional bits of operands and result (0 <= FRAC < WIDTH).
- ROUND_EN, 1, 1 = round half toward +inf; 0 = truncate (floor).
- SAT_EN, 1, 1 = saturate on overflow; 0 = wrap (keep low WIDTH bits of the shifted product).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  signed multiplicand, two's complement Q format.
- b  in  WIDTH  signed multiplier, same format.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  WIDTH  signed rounded/saturated product.
- overflow  out  1  result exceeded range; qualified by out_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On rst: state=IDLE, in_ready=0 during the reset cycle and 1 on the first cycle after, out_valid=0, result=0, overflow=0, accumulator and counter cleared.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch |a|, |b| as WIDTH-bit unsigned magnitudes. |−2^(WIDTH-1)| = 2^(WIDTH-1) fits unsigned.
  - Also latch sign = a[MSB]^b[MSB], clear the 2*WIDTH-bit accumulator, set cnt=0, go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle: if multiplier LSB=1, acc += multiplicand<<cnt; shift multiplier right; cnt++.
  - After WIDTH cycles (cnt==WIDTH-1 on the last cycle), go to FINISH.
- FINISH (1 cycle):
  - P = sign ? −acc : acc, 2*WIDTH+1 bits signed.
  - If ROUND_EN and FRAC>0: R = (P + 2^(FRAC-1)) >>> FRAC; else R = P >>> FRAC.
  - If SAT_EN: clamp R to [−2^(WIDTH-1), 2^(WIDTH-1)−1].
  - If not SAT_EN: keep R[WIDTH-1:0].
  - overflow=1 iff R is outside range, in both modes.
  - Register result and overflow, set out_valid=1, go to DONE.
- DONE:
  - result and overflow are held stable while out_valid=1 and out_ready=0.
  - On out_ready: out_valid=0 and go to IDLE on the next edge.
  - A new operand is accepted no earlier than the cycle after that.
- Latency and throughput:
  - Accept at edge T0; out_valid rises after edge T0+WIDTH+1.
  - Throughput is one result per WIDTH+3 cycles with out_ready held high.
- Boundary conditions:
  - Inputs are ignored outside IDLE, and in_valid never affects an in-flight operation. a and b may change freely after acceptance.
  - A zero operand still takes full latency; there is no early exit.
  - out_ready asserted before out_valid has no effect.
  - rst in any state aborts the operation immediately: no result is emitted and out_valid=0 after the edge.
  - FRAC=0: no rounding; result is the integer product with saturation.

Decomposition:
- Shared package fxp_pkg:
  - state enum {IDLE, CALC, FINISH, DONE};
  - localparams for the global RK Q format (WIDTH, FRAC);
  - a function or constant giving MAX = 2^(WIDTH-1)−1 and MIN = −2^(WIDTH-1).
- One natural sub-module: fxp_round_sat, combinational. It takes the signed 2*WIDTH+1 product and outputs the rounded/saturated WIDTH-bit result plus overflow. It is reused by the planned fixed-point adder.

Test Plan (WIDTH=16, FRAC=8, ROUND_EN=1, SAT_EN=1 unless noted):
- a=0x0180 (1.5), b=0x0200 (2.0) -> result=0x0300, overflow=0, out_valid exactly 17 cycles after accept; a=0xFE80 (−1.5) gives 0xFD00.
- Rounding:
  - a=0x0001, b=0x0080 -> 0x0001;
  - a=0xFFFF, b=0x0080 -> 0x0000;
  - same operands with ROUND_EN=0 -> 0x0000 and 0xFFFF respectively.
- Overflow:
  - a=0x7F00, b=0x0200 -> 0x7FFF, overflow=1;
  - a=0x8000, b=0x8000 -> 0x7FFF, overflow=1;
  - a=0x8000, b=0x0200 with SAT_EN=0 -> 0x0000, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. result is stable, in_ready=0, and in_valid pulses are ignored. Release -> one transfer, then in_ready=1 the next cycle.
- Reset mid-operation: assert rst 6 cycles into CALC. Next cycle out_valid=0, in_ready=1. A new op 0x0100×0x0100 -> 0x0100 with correct latency.
- Random signed operands, 10k ops, random out_ready: compare against a golden model (round-half-up shift, clamp), including ±MAX and MIN corner cases.
